dc_write_ctrl_hyper: RTL and testbench
======================================

# dc_write_ctrl_hyper

Write-side controller for the uDMA HyperBus dual-clock data buffer, running entirely in the writer's clock domain. It accepts words from the upstream producer over a valid/ready handshake and drives the buffer's write enable, one-hot write pointer and write data. It tracks the one-hot read pointer coming from the reader's domain through an internal synchronizer and derives `full` and a free-slot count from it.

## Interface
- `DATA_WIDTH`, 32, word width.
- `BUFFER_DEPTH`, 8, number of buffer entries; also the width of the one-hot pointers; must be ≥ 2.
- `SYNC_STAGES`, 2, flops in the read-pointer synchronizer; must be ≥ 2.

- `clk`  in  1  writer-domain clock; everything is clocked on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  controller can accept a word; equals `!full`.
- `in_data`  in  DATA_WIDTH  upstream word.
- `read_pointer_async`  in  BUFFER_DEPTH  one-hot read pointer from the reader domain; asynchronous to `clk`.
- `write_enable`  out  1  buffer write strobe.
- `write_pointer`  out  BUFFER_DEPTH  one-hot write pointer, registered; goes to the buffer and to the read-side controller.
- `write_data`  out  DATA_WIDTH  word to write; a combinational copy of `in_data`.
- `full`  out  1  buffer holds BUFFER_DEPTH-1 words, as seen by this domain.
- `free_slots`  out  $clog2(BUFFER_DEPTH)  conservative count of writable entries, range 0..BUFFER_DEPTH-1.

## Operation
- **Write pointer**
  - Register `wp`, one-hot. Reset value is bit 0 set (`'b…0001`).
  - On a handshake it rotates left by one; bit BUFFER_DEPTH-1 wraps to bit 0.
- **Handshake**
  - `write_enable = in_valid & in_ready`, combinational.
  - `write_data = in_data`.
  - `wp` advances on the same edge as the accepted write, so the buffer captures data at the old `wp`.
  - When `in_ready` is low, `in_data` is not consumed; the upstream must hold it.
- **Synchronizer**
  - `SYNC_STAGES` flops sample `read_pointer_async`. Every stage resets to bit 0 set.
- **Stable capture**
  - Register `rp_stable` loads the last synchronizer stage only when that stage has exactly one bit set.
  - Zero-hot or multi-hot samples (a pointer caught mid-transition) are ignored and `rp_stable` holds.
  - Reset value is bit 0 set.
  - `rp_stable` therefore always holds a valid, possibly stale pointer, so every flag it drives is conservative.
- **Full**
  - `full = (rotl(wp) == rp_stable)`.
  - One slot is always left unused, so capacity is BUFFER_DEPTH-1.
  - `full` is derived from registers only; it is not combinational from `in_valid`.
- **Free count**
  - `wb` and `rb` are the binary indices of `wp` and `rp_stable`.
  - Compute `d = rb - wb - 1` in $clog2(BUFFER_DEPTH)+1 signed bits.
  - `free_slots = d < 0 ? d + BUFFER_DEPTH : d`.
  - Invariant: `full == (free_slots == 0)`.
- **Reset values**
  - `in_ready` = 1, `full` = 0, `free_slots` = BUFFER_DEPTH-1.
  - `write_pointer` = bit 0 set.
  - `write_enable` = `in_valid`.

## Timing
- Write latency: a word accepted at edge N is in the buffer after edge N. `write_pointer` shows the next slot from cycle N+1.
- `full` and `free_slots` reflect a write one cycle after the accepting edge.
- A read-pointer advance in the reader domain reaches `rp_stable` within SYNC_STAGES+1 `clk` edges plus up to one cycle of sampling uncertainty. `full` and `free_slots` update in the same cycle `rp_stable` does.
- Simultaneous write and `rp_stable` update on the same edge: both take effect. Free count change is −1+k, where k is the read advance.
- While full, a read advance deasserts `full` only after the stable capture. No write is accepted before then.
- Reset mid-operation: all state returns to its reset value on the next edge regardless of handshake. The read side must be reset in the same window; the buffer contents are not cleared by this block.

## Test plan
- **Reset:** hold `rst` 3 cycles with `in_valid`=1 → `write_pointer`=`8'h01`, `full`=0, `free_slots`=7, `in_ready`=1, no pointer advance while `rst` is high.
- **Fill:** read pointer fixed at `8'h01`, 8 back-to-back valid words → first 7 accepted with `write_enable` high, `write_pointer` steps `02,04,…,80`, `full`=1 and `free_slots`=0 after the 7th write, 8th word held with `in_ready`=0.
- **Drain latency:** from full, step `read_pointer_async` to `8'h02` → `full` deasserts and `free_slots`=1 exactly SYNC_STAGES+1 edges later (±1); the held word is then written at pointer `8'h80`.
- **Glitch:** drive `read_pointer_async` to `8'h06` for 3 cycles, then `8'h00` for 3 cycles → `rp_stable`, `full` and `free_slots` unchanged; then `8'h04` → accepted.
- **Wrap:** 20 writes with the read pointer trailing by 3 slots → `write_pointer` wraps `80`→`01`; `free_slots` computes correctly across the wrap each cycle; scoreboard matches data order.
- **Mid-op reset:** assert `rst` with 5 words stored and `in_valid` high → next cycle `write_pointer`=`8'h01`, `free_slots`=7, synchronizer output reads `8'h01` until a new sample propagates.

Source files
------------

// File: rtl/dc_write_ctrl_hyper.sv
// Write-side controller for the HyperBus dual-clock buffer (writer domain).
// Ports: clk/rst, in_* handshake, read_pointer_async in, write_* to buffer, full/free_slots.
module dc_write_ctrl_hyper #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic [BUFFER_DEPTH-1:0]         read_pointer_async,
  output logic                            write_enable,
  output logic [BUFFER_DEPTH-1:0]         write_pointer,
  output logic [DATA_WIDTH-1:0]           write_data,
  output logic                            full,
  output logic [$clog2(BUFFER_DEPTH)-1:0] free_slots
);

  localparam int D  = BUFFER_DEPTH;
  localparam int AW = $clog2(BUFFER_DEPTH);

  localparam logic [D-1:0]  ONE      = {{(D-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   ONE_W    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] DEPTH_LO = AW'(BUFFER_DEPTH);

  function automatic logic [AW-1:0] oh2bin(input logic [D-1:0] oh);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      if (oh[i]) r = r | AW'(i);
    end
    return r;
  endfunction

  logic [D-1:0]  wp_q, wp_d, wp_rot;
  logic [D-1:0]  rp_stable_q, rp_stable_d;
  logic [D-1:0]  sync_q [SYNC_STAGES];
  logic [D-1:0]  sync_last;
  logic          rp_onehot;
  logic          accept;
  logic [AW-1:0] wb, rb;
  logic [AW:0]   d;

  assign wp_rot = {wp_q[D-2:0], wp_q[D-1]};

  assign full         = (wp_rot == rp_stable_q);
  assign in_ready     = !full;
  assign accept       = in_valid & in_ready;
  assign write_enable = accept;
  assign write_data   = in_data;
  assign write_pointer = wp_q;

  assign wp_d = accept ? wp_rot : wp_q;

  // A pointer caught mid-transition is zero- or multi-hot; keep the
  // last clean value so flags stay conservative.
  assign sync_last = sync_q[SYNC_STAGES-1];
  assign rp_onehot = (sync_last != '0) &&
                     ((sync_last & (sync_last - ONE)) == '0);
  assign rp_stable_d = rp_onehot ? sync_last : rp_stable_q;

  // d = rb - wb - 1 in two's complement; wrap by adding the depth
  // when negative.
  assign wb = oh2bin(wp_q);
  assign rb = oh2bin(rp_stable_q);
  assign d  = {1'b0, rb} - {1'b0, wb} - ONE_W;
  assign free_slots = d[AW] ? (d[AW-1:0] + DEPTH_LO) : d[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q        <= ONE;
      rp_stable_q <= ONE;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= ONE;
    end else begin
      wp_q        <= wp_d;
      rp_stable_q <= rp_stable_d;
      sync_q[0]   <= read_pointer_async;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

endmodule

// File: tb/tb_dc_write_ctrl_hyper.sv
// Scoreboard bench for dc_write_ctrl_hyper: directed vectors, writes
// checked by a monitor against a queue of expected (data, slot) pairs.
module tb_dc_write_ctrl_hyper;

  localparam int DW = 32;
  localparam int D  = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [D-1:0]  rpa = 8'h01;
  logic          write_enable;
  logic [D-1:0]  write_pointer;
  logic [DW-1:0] write_data;
  logic          full;
  logic [2:0]    free_slots;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [D-1:0]  ptr;
  } exp_t;

  exp_t sbq[$];

  dc_write_ctrl_hyper #(
    .DATA_WIDTH(DW), .BUFFER_DEPTH(D), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .read_pointer_async(rpa),
    .write_enable(write_enable),
    .write_pointer(write_pointer),
    .write_data(write_data),
    .full(full),
    .free_slots(free_slots)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [D-1:0] oh(input int n);
    logic [D-1:0] r;
    r = 8'h01 << (n % D);
    return r;
  endfunction

  // Monitor: a write happens on the edge after any negedge where
  // write_enable is high outside reset.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && write_enable) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got write %0h expected none",
                 write_data);
      end else begin
        e = sbq.pop_front();
        check("sb_data", {32'h0, write_data}, {32'h0, e.data});
        check("sb_ptr", {56'h0, write_pointer}, {56'h0, e.ptr});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [DW-1:0] dd, input logic [D-1:0] p);
    sbq.push_back('{data: dd, ptr: p});
    in_data  = dd;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready && !rst;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept");
    end
  endtask

  task automatic send(input logic [DW-1:0] dd, input logic [D-1:0] p);
    present(dd, p);
    wait_accept();
    in_valid = 1'b0;
  endtask

  task automatic flags(input string nm, input logic f,
                       input logic [2:0] fs);
    check({nm, "_full"}, {63'h0, full}, {63'h0, f});
    check({nm, "_free"}, {61'h0, free_slots}, {61'h0, fs});
    check({nm, "_rdy"}, {63'h0, in_ready}, {63'h0, !f});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int wi;

    // Reset held with valid high: pointer must not move.
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    rpa = 8'h01;
    repeat (3) begin
      cyc();
      check("rst_wp", {56'h0, write_pointer}, 64'h01);
      check("rst_we", {63'h0, write_enable}, 64'h1);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_wp_out", {56'h0, write_pointer}, 64'h01);
    flags("rst", 1'b0, 3'd7);

    // Fill: 7 words, read pointer parked at slot 0.
    for (int k = 0; k < 7; k++) begin
      send(32'hA000_0000 + k, oh(k));
      check("fill_wp", {56'h0, write_pointer}, {56'h0, oh(k + 1)});
      flags("fill", k == 6, 3'(6 - k));
    end
    present(32'hA000_0007, 8'h80);
    cyc();
    check("held_we", {63'h0, write_enable}, 64'h0);
    check("held_rdy", {63'h0, in_ready}, 64'h0);

    // Drain latency.
    rpa = 8'h02;
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      cyc();
      if (!full) n = i;
    end
    check("drain_lat", {63'h0, (n >= SS && n <= SS + 2)}, 64'h1);
    check("drain_free", {61'h0, free_slots}, 64'h1);
    wait_accept();
    in_valid = 1'b0;
    check("drain_wp", {56'h0, write_pointer}, 64'h01);
    flags("drain", 1'b1, 3'd0);

    // Glitch: multi-hot then zero-hot samples are ignored.
    present(32'hB000_0000, 8'h01);
    rpa = 8'h06;
    repeat (3) begin
      cyc();
      flags("glitch_mh", 1'b1, 3'd0);
    end
    rpa = 8'h00;
    repeat (3) begin
      cyc();
      flags("glitch_zh", 1'b1, 3'd0);
    end
    rpa = 8'h04;
    wait_accept();
    in_valid = 1'b0;
    check("glitch_wp", {56'h0, write_pointer}, 64'h02);
    flags("glitch", 1'b1, 3'd0);

    // Wrap: reader kept 3 slots behind the writer.
    wi = 1;
    for (int j = 0; j < 20; j++) begin
      rpa = oh(wi + 5);
      repeat (4) cyc();
      flags("wrap_pre", 1'b0, 3'd4);
      send(32'hC000_0000 + j, oh(wi));
      wi++;
      check("wrap_wp", {56'h0, write_pointer}, {56'h0, oh(wi)});
      check("wrap_free", {61'h0, free_slots}, 64'h3);
    end

    // One more word: 5 stored.
    send(32'hD000_0000, oh(wi));
    wi++;
    check("mid_free", {61'h0, free_slots}, 64'h2);

    // Mid-operation reset with valid high.
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hEEEE_EEEE;
    cyc();
    check("mrst_wp", {56'h0, write_pointer}, 64'h01);
    flags("mrst", 1'b0, 3'd7);
    cyc();
    flags("mrst_hold", 1'b0, 3'd7);
    rst = 1'b0;
    in_valid = 1'b0;
    rpa = 8'h01;
    repeat (4) cyc();
    flags("mrst_post", 1'b0, 3'd7);
    send(32'hF000_0000, 8'h01);
    check("mrst_wp2", {56'h0, write_pointer}, 64'h02);
    flags("mrst_wr", 1'b0, 3'd6);

    repeat (3) cyc();
    check("sb_empty", 64'(sbq.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
